// File: rtl/frame_buffer_pkg.sv
// Shared defaults and clear-engine state encoding for the frame buffer.
// Default geometry is 320x240 words of RGB565.
package frame_buffer_pkg;

  localparam int FB_DW    = 16;
  localparam int FB_AW    = 17;
  localparam int FB_DEPTH = 76800;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } fb_state_e;

endpackage

// File: rtl/dp_ram_core.sv
// Plain dual-port storage: one write port, one registered read port, no reset.
// Read data appears one cycle after i_re; a same-address write in that cycle returns the old word.
module dp_ram_core
  import frame_buffer_pkg::*;
#(
  parameter int DW    = FB_DW,
  parameter int AW    = FB_AW,
  parameter int DEPTH = FB_DEPTH
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/frame_buffer_dp.sv
// Range-checked dual-port frame buffer with a whole-frame clear engine; read latency 1 cycle.
// No backpressure: rejected writes (out of range or engine busy) are dropped and flagged on o_wr_err.
module frame_buffer_dp
  import frame_buffer_pkg::*;
#(
  parameter int            DW        = FB_DW,
  parameter int            AW        = FB_AW,
  parameter int            DEPTH     = FB_DEPTH,
  parameter logic [DW-1:0] CLR_VALUE = '0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  output logic          o_wr_err,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data,
  output logic          o_rd_valid,
  output logic          o_rd_err,
  input  logic          i_clr_start,
  output logic          o_busy,
  output logic          o_clr_done
);

  localparam int            IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LP_LAST  = AW'(DEPTH - 1);

  fb_state_e     r_state;
  logic [AW-1:0] r_cnt;
  logic          r_busy;
  logic          r_clr_done;
  logic          r_wr_err;
  logic          r_rd_valid;
  logic          r_rd_err;
  logic          r_rd_zero;

  logic          w_wr_in_rng;
  logic          w_rd_in_rng;
  logic          w_eng_we;
  logic          w_ext_we;
  logic          w_ram_we;
  logic          w_ram_re;
  logic [IW-1:0] w_ram_waddr;
  logic [DW-1:0] w_ram_wdata;
  logic [DW-1:0] w_ram_q;

  // Extra MSB keeps the compare correct when DEPTH == 2**AW.
  assign w_wr_in_rng = ({1'b0, i_wr_addr} < LP_DEPTH);
  assign w_rd_in_rng = ({1'b0, i_rd_addr} < LP_DEPTH);

  assign w_eng_we    = (r_state == ST_CLEAR);
  assign w_ext_we    = i_wr_en && w_wr_in_rng && !r_busy;
  assign w_ram_we    = w_eng_we || w_ext_we;
  assign w_ram_waddr = w_eng_we ? r_cnt[IW-1:0] : i_wr_addr[IW-1:0];
  assign w_ram_wdata = w_eng_we ? CLR_VALUE : i_wr_data;
  assign w_ram_re    = i_rd_en && w_rd_in_rng;

  dp_ram_core #(
    .DW    (DW),
    .AW    (IW),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_re    (w_ram_re),
    .i_raddr (i_rd_addr[IW-1:0]),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_clr_done <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_clr_start) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (r_cnt == LP_LAST) begin
            r_state    <= ST_DONE;
            r_busy     <= 1'b0;
            r_clr_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_state    <= ST_IDLE;
          r_clr_done <= 1'b0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_clr_done <= 1'b0;
        end
      endcase
    end
  end

  // r_rd_zero masks the RAM output after reset and after an out-of-range read until the next read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_err   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
      r_rd_zero  <= 1'b1;
    end else begin
      r_wr_err   <= i_wr_en && (!w_wr_in_rng || r_busy);
      r_rd_valid <= i_rd_en;
      r_rd_err   <= i_rd_en && !w_rd_in_rng;
      if (i_rd_en) r_rd_zero <= !w_rd_in_rng;
    end
  end

  assign o_rd_data  = r_rd_zero ? '0 : w_ram_q;
  assign o_rd_valid = r_rd_valid;
  assign o_rd_err   = r_rd_err;
  assign o_wr_err   = r_wr_err;
  assign o_busy     = r_busy;
  assign o_clr_done = r_clr_done;

endmodule

// File: tb/tb_frame_buffer_dp.sv
// Directed bench: full-size instance for data-path vectors, 16-word instance for the clear engine.
module tb_frame_buffer_dp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [16:0] rd_addr;
  logic        clr_b;
  logic        clr_s;

  logic        b_wr_err, b_rd_valid, b_rd_err, b_busy, b_clr_done;
  logic [15:0] b_rd_data;
  logic        s_wr_err, s_rd_valid, s_rd_err, s_busy, s_clr_done;
  logic [15:0] s_rd_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  frame_buffer_dp dut_big (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_err(b_wr_err),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(b_rd_data),
    .o_rd_valid(b_rd_valid), .o_rd_err(b_rd_err),
    .i_clr_start(clr_b), .o_busy(b_busy), .o_clr_done(b_clr_done)
  );

  frame_buffer_dp #(.DEPTH(16), .CLR_VALUE(16'hFFFF)) dut_small (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_err(s_wr_err),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(s_rd_data),
    .o_rd_valid(s_rd_valid), .o_rd_err(s_rd_err),
    .i_clr_start(clr_s), .o_busy(s_busy), .o_clr_done(s_clr_done)
  );

  typedef struct packed {
    logic        we;
    logic [16:0] wa;
    logic [15:0] wd;
    logic        re;
    logic [16:0] ra;
    logic [15:0] e_dat;
    logic        e_vld;
    logic        e_rerr;
    logic        e_werr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic we, logic [16:0] wa, logic [15:0] wd, logic re,
                              logic [16:0] ra, logic [15:0] e_dat, logic e_vld,
                              logic e_rerr, logic e_werr);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
    v.e_dat = e_dat; v.e_vld = e_vld; v.e_rerr = e_rerr; v.e_werr = e_werr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wr_one(input logic [16:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic chk_small_zero(input string tag);
    chk({tag, " s_rd_data"},  32'(s_rd_data),  32'd0);
    chk({tag, " s_rd_valid"}, 32'(s_rd_valid), 32'd0);
    chk({tag, " s_rd_err"},   32'(s_rd_err),   32'd0);
    chk({tag, " s_wr_err"},   32'(s_wr_err),   32'd0);
    chk({tag, " s_busy"},     32'(s_busy),     32'd0);
    chk({tag, " s_clr_done"}, 32'(s_clr_done), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; clr_b = 1'b0; clr_s = 1'b0;

    tbl.push_back(mk(1, 17'd0,      16'd234,   0, 17'd0,      16'd0,     0, 0, 0));
    tbl.push_back(mk(0, 17'd0,      16'd0,     1, 17'd0,      16'd234,   1, 0, 0));
    tbl.push_back(mk(1, 17'd76799,  16'hABCD,  0, 17'd0,      16'd234,   0, 0, 0));
    tbl.push_back(mk(0, 17'd0,      16'd0,     1, 17'd76799,  16'hABCD,  1, 0, 0));
    tbl.push_back(mk(1, 17'd76800,  16'h1234,  0, 17'd0,      16'hABCD,  0, 0, 1));
    tbl.push_back(mk(0, 17'd0,      16'd0,     1, 17'd76800,  16'd0,     1, 1, 0));
    tbl.push_back(mk(0, 17'd0,      16'd0,     1, 17'd0,      16'd234,   1, 0, 0));
    tbl.push_back(mk(0, 17'd0,      16'd0,     1, 17'd76799,  16'hABCD,  1, 0, 0));
    tbl.push_back(mk(1, 17'd5,      16'd7,     0, 17'd0,      16'hABCD,  0, 0, 0));
    tbl.push_back(mk(1, 17'd5,      16'd9,     1, 17'd5,      16'd7,     1, 0, 0));
    tbl.push_back(mk(0, 17'd0,      16'd0,     1, 17'd5,      16'd9,     1, 0, 0));
    tbl.push_back(mk(1, 17'd131071, 16'h5555,  0, 17'd0,      16'd9,     0, 0, 1));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 17'(i), 16'(10 + i), 0, 17'd0, 16'd9, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 17'd0, 16'd0, 1, 17'(i), 16'(10 + i), 1, 0, 0));
    tbl.push_back(mk(0, 17'd0,      16'd0,     0, 17'd0,      16'd13,    0, 0, 0));

    repeat (2) @(negedge clk);
    chk("rst b_rd_data",  32'(b_rd_data),  32'd0);
    chk("rst b_rd_valid", 32'(b_rd_valid), 32'd0);
    chk("rst b_rd_err",   32'(b_rd_err),   32'd0);
    chk("rst b_wr_err",   32'(b_wr_err),   32'd0);
    chk("rst b_busy",     32'(b_busy),     32'd0);
    chk("rst b_clr_done", 32'(b_clr_done), 32'd0);
    chk_small_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      rd_en = tbl[i].re; rd_addr = tbl[i].ra;
      @(negedge clk);
      chk($sformatf("row%0d rd_data", i),  32'(b_rd_data),  32'(tbl[i].e_dat));
      chk($sformatf("row%0d rd_valid", i), 32'(b_rd_valid), 32'(tbl[i].e_vld));
      chk($sformatf("row%0d rd_err", i),   32'(b_rd_err),   32'(tbl[i].e_rerr));
      chk($sformatf("row%0d wr_err", i),   32'(b_wr_err),   32'(tbl[i].e_werr));
    end
    wr_en = 1'b0; rd_en = 1'b0;

    // Full clear of the 16-word instance, with a busy-time write and ignored restarts.
    for (int i = 0; i < 16; i++) wr_one(17'(i), 16'(100 + i));
    clr_s = 1'b1;
    @(negedge clk);
    clr_s = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("clr busy c%0d", i), 32'(s_busy), 32'd1);
      chk($sformatf("clr done c%0d", i), 32'(s_clr_done), 32'd0);
      if (i == 5) clr_s = 1'b1;
      if (i == 6) clr_s = 1'b0;
      if (i == 15) begin
        wr_en = 1'b1; wr_addr = 17'd0; wr_data = 16'h1234;
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
    chk("done busy",   32'(s_busy),     32'd0);
    chk("done pulse",  32'(s_clr_done), 32'd1);
    chk("busy wr_err", 32'(s_wr_err),   32'd1);
    clr_s = 1'b1;
    @(negedge clk);
    clr_s = 1'b0;
    chk("post busy",   32'(s_busy),     32'd0);
    chk("post done",   32'(s_clr_done), 32'd0);
    chk("post wr_err", 32'(s_wr_err),   32'd0);
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1; rd_addr = 17'(i);
      @(negedge clk);
      chk($sformatf("clr rd%0d", i), 32'(s_rd_data), 32'hFFFF);
    end
    rd_en = 1'b0;

    // Reset asserted after eight words of a second clear.
    for (int i = 0; i < 16; i++) wr_one(17'(i), 16'(200 + i));
    clr_s = 1'b1;
    @(negedge clk);
    clr_s = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("abort busy c%0d", i), 32'(s_busy), 32'd1);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk_small_zero("abort");
    repeat (2) begin
      @(negedge clk);
      chk("abort no done", 32'(s_clr_done), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort idle busy", 32'(s_busy),     32'd0);
    chk("abort idle done", 32'(s_clr_done), 32'd0);
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1; rd_addr = 17'(i);
      @(negedge clk);
      chk($sformatf("abort rd%0d", i), 32'(s_rd_data),
          (i < 8) ? 32'hFFFF : 32'(200 + i));
    end
    rd_en = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
